stdp_sweep_scheduler: RTL and testbench

//  Sequences one shared STDP weight-change datapath (t_change, a_plus, tau_plus -> weight_change, Q16.16) across NUM_SYN synapses.

---
 rtl/stdp_pkg.sv | 43 ++++
 rtl/stdp_weight_bank.sv | 44 ++++
 rtl/stdp_sweep_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_stdp_sweep_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types, Q16.16 constants and saturation helper for the STDP sweep scheduler
//
// Purpose: FSM state encoding, fixed-point constants and the N+1 -> N clamp
//          used when a weight change is written back.
// Ports:   none (package).
package stdp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } fsm_t;

  localparam int FX_W = 32;
  localparam int FX_Q = 16;

  localparam logic [FX_W-1:0] FX_ONE  = 32'h0001_0000;
  localparam logic [FX_W-1:0] FX_HALF = 32'h0000_8000;
  localparam logic [FX_W-1:0] FX_ZERO = 32'h0000_0000;

  // Clamp a signed (FX_W+1)-bit sum into [lo, hi]. The extra bit means the
  // comparison itself can never overflow.
  function automatic logic [FX_W-1:0] sat_clamp(
    input logic signed [FX_W:0]   v,
    input logic signed [FX_W-1:0] lo,
    input logic signed [FX_W-1:0] hi
  );
    logic signed [FX_W:0] lo_x;
    logic signed [FX_W:0] hi_x;
    lo_x = {lo[FX_W-1], lo};
    hi_x = {hi[FX_W-1], hi};
    if (v < lo_x) begin
      sat_clamp = lo;
    end else if (v > hi_x) begin
      sat_clamp = hi;
    end else begin
      sat_clamp = v[FX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/stdp_weight_bank.sv
// rtl/stdp_weight_bank.sv - NUM_SYN x N synaptic weight register file
//
// Purpose: holds one weight per synapse; one write port, two combinational
//          read ports (external consumer, and the sweep's read-modify-write).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset (weights -> W_INIT)
//   wr_en/wr_idx/wr_data  write port
//   rd_idx/rd_data      external combinational read port
//   sw_idx/sw_data      sweep combinational read port
module stdp_weight_bank
  import stdp_pkg::*;
#(
  parameter int              N       = FX_W,
  parameter int              NUM_SYN = 8,
  parameter logic [N-1:0]    W_INIT  = FX_HALF,
  parameter int              IW      = $clog2(NUM_SYN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [N-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [N-1:0]  rd_data,
  input  logic [IW-1:0] sw_idx,
  output logic [N-1:0]  sw_data
);

  logic [N-1:0] mem [NUM_SYN];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SYN; i++) begin
        mem[i] <= W_INIT;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
  assign sw_data = mem[sw_idx];

endmodule

// File: rtl/stdp_sweep_scheduler.sv
// rtl/stdp_sweep_scheduler.sv - time-multiplexes one STDP datapath across NUM_SYN synapses
//
// Purpose: records the last pre-spike time per synapse; on a post-spike walks
//          every synapse with a recorded pre-spike, drives the shared datapath
//          with t_post - t_pre[i], waits DP_LAT cycles, and adds the returned
//          weight change to weight[i] with saturation to [W_MIN, W_MAX].
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   time_now                     current time, Q16.16
//   pre_spike[NUM_SYN]           per-synapse pre-spike strobes
//   post_spike                   post-synaptic spike strobe
//   a_plus, tau_plus             datapath config, sampled at sweep start
//   dp_t_change/a_plus/tau_plus  registered datapath operands
//   dp_weight_change             datapath result, valid DP_LAT cycles after operands
//   rd_idx/rd_weight             combinational weight read
//   busy, done, post_dropped     status (done and post_dropped are 1-cycle pulses)
module stdp_sweep_scheduler
  import stdp_pkg::*;
#(
  parameter int           N       = FX_W,
  parameter int           Q       = FX_Q,
  parameter int           NUM_SYN = 8,
  parameter int           DP_LAT  = 1,
  parameter logic [N-1:0] W_INIT  = FX_HALF,
  parameter logic [N-1:0] W_MIN   = FX_ZERO,
  parameter logic [N-1:0] W_MAX   = FX_ONE,
  localparam int          IW      = $clog2(NUM_SYN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       time_now,
  input  logic [NUM_SYN-1:0] pre_spike,
  input  logic               post_spike,
  input  logic [N-1:0]       a_plus,
  input  logic [N-1:0]       tau_plus,
  output logic [N-1:0]       dp_t_change,
  output logic [N-1:0]       dp_a_plus,
  output logic [N-1:0]       dp_tau_plus,
  input  logic [N-1:0]       dp_weight_change,
  input  logic [IW-1:0]      rd_idx,
  output logic [N-1:0]       rd_weight,
  output logic               busy,
  output logic               done,
  output logic               post_dropped
);

  localparam int CW = $clog2(DP_LAT + 1);

  fsm_t state, state_nxt;

  logic [IW-1:0]      idx;
  logic               last;
  logic [N-1:0]       t_pre [NUM_SYN];
  logic [NUM_SYN-1:0] has_pre;
  logic [N-1:0]       t_post, cfg_a, cfg_tau;
  logic               pend;
  logic [N-1:0]       pend_time, pend_a, pend_tau;
  logic [CW-1:0]      cnt;
  logic [N-1:0]       wc_q;
  logic               bank_wr_en;
  logic [N-1:0]       sweep_weight;
  logic signed [N:0]  wsum;
  logic [N-1:0]       wr_data;

  assign last = (idx == IW'(NUM_SYN - 1));

  // Sum at N+1 bits so the clamp sees the true value, never a wrapped one.
  always_comb begin
    wsum    = $signed({sweep_weight[N-1], sweep_weight}) + $signed({wc_q[N-1], wc_q});
    wr_data = sat_clamp(wsum, W_MIN, W_MAX);
  end

  stdp_weight_bank #(
    .N       (N),
    .NUM_SYN (NUM_SYN),
    .W_INIT  (W_INIT),
    .IW      (IW)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bank_wr_en),
    .wr_idx  (idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_weight),
    .sw_idx  (idx),
    .sw_data (sweep_weight)
  );

  // Pre-spike capture is independent of the sweep. A sweep issuing synapse i
  // in the same cycle reads the old t_pre[i]/has_pre[i] (register semantics).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      has_pre <= '0;
      for (int i = 0; i < NUM_SYN; i++) begin
        t_pre[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SYN; i++) begin
        if (pre_spike[i]) begin
          t_pre[i]   <= time_now;
          has_pre[i] <= 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A post-spike landing in FIN is forwarded straight into
  // the next sweep, so pending can never be left set while IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (post_spike) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (has_pre[idx])  state_nxt = S_WAIT;
        else if (last)     state_nxt = S_FIN;
      end
      S_WAIT:  if (cnt == CW'(1)) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last ? S_FIN : S_ISSUE;
      S_FIN:   state_nxt = (pend || post_spike) ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
    bank_wr_en = (state == S_WRITE);
  end

  // Sweep datapath registers and the single-deep post-spike queue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx          <= '0;
      t_post       <= '0;
      cfg_a        <= '0;
      cfg_tau      <= '0;
      pend         <= 1'b0;
      pend_time    <= '0;
      pend_a       <= '0;
      pend_tau     <= '0;
      cnt          <= '0;
      wc_q         <= '0;
      dp_t_change  <= '0;
      dp_a_plus    <= '0;
      dp_tau_plus  <= '0;
      post_dropped <= 1'b0;
    end else begin
      post_dropped <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (post_spike) begin
            t_post  <= time_now;
            cfg_a   <= a_plus;
            cfg_tau <= tau_plus;
            idx     <= '0;
          end
        end
        S_ISSUE: begin
          if (has_pre[idx]) begin
            dp_t_change <= t_post - t_pre[idx];
            dp_a_plus   <= cfg_a;
            dp_tau_plus <= cfg_tau;
            cnt         <= CW'(DP_LAT);
          end else if (!last) begin
            idx <= idx + IW'(1);
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) wc_q <= dp_weight_change;
        end
        S_WRITE: begin
          if (!last) idx <= idx + IW'(1);
        end
        S_FIN: begin
          // A post-spike arriving now is the newest request and wins over
          // any stored copy.
          if (post_spike) begin
            t_post  <= time_now;
            cfg_a   <= a_plus;
            cfg_tau <= tau_plus;
            idx     <= '0;
          end else if (pend) begin
            t_post  <= pend_time;
            cfg_a   <= pend_a;
            cfg_tau <= pend_tau;
            idx     <= '0;
          end
        end
        default: ;
      endcase

      if (state == S_FIN) begin
        pend <= 1'b0;
        if (post_spike && pend) post_dropped <= 1'b1;
      end else if (state != S_IDLE && post_spike) begin
        pend      <= 1'b1;
        pend_time <= time_now;
        pend_a    <= a_plus;
        pend_tau  <= tau_plus;
        if (pend) post_dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stdp_sweep_scheduler.sv
// tb/tb_stdp_sweep_scheduler.sv - directed self-checking bench for stdp_sweep_scheduler
module tb_stdp_sweep_scheduler;

  localparam int N       = 32;
  localparam int NUM_SYN = 8;
  localparam int IW      = 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N-1:0]       time_now;
  logic [NUM_SYN-1:0] pre_spike;
  logic               post_spike;
  logic [N-1:0]       a_plus, tau_plus;
  logic [N-1:0]       dp_t_change, dp_a_plus, dp_tau_plus;
  logic [N-1:0]       dp_weight_change;
  logic [IW-1:0]      rd_idx;
  logic [N-1:0]       rd_weight;
  logic               busy, done, post_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stdp_sweep_scheduler #(
    .N       (N),
    .NUM_SYN (NUM_SYN),
    .DP_LAT  (1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .time_now         (time_now),
    .pre_spike        (pre_spike),
    .post_spike       (post_spike),
    .a_plus           (a_plus),
    .tau_plus         (tau_plus),
    .dp_t_change      (dp_t_change),
    .dp_a_plus        (dp_a_plus),
    .dp_tau_plus      (dp_tau_plus),
    .dp_weight_change (dp_weight_change),
    .rd_idx           (rd_idx),
    .rd_weight        (rd_weight),
    .busy             (busy),
    .done             (done),
    .post_dropped     (post_dropped)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n    = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    time_now   = '0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic pulse_pre(input int i, input logic [N-1:0] t);
    time_now     = t;
    pre_spike[i] = 1'b1;
    tick;
    pre_spike = '0;
  endtask

  // Post-spike in cycle 0; kd = cycle in which done is seen (0 on timeout).
  task automatic run_sweep(input logic [N-1:0] t, output int kd);
    kd         = 0;
    time_now   = t;
    post_spike = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick;
      post_spike = 1'b0;
      if (done) begin
        kd = k;
        break;
      end
    end
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < NUM_SYN; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_weight !== 32'h0000_8000) begin
        errors++;
        $display("FAIL reset_weight[%0d] got %h want 00008000", i, rd_weight);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (post_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got %b want 0", post_dropped); end
    checks++; if (dp_t_change !== 32'h0) begin errors++; $display("FAIL reset_dp_t got %h want 0", dp_t_change); end
  endtask

  task automatic test_single;
    logic [N-1:0] tc, ap, tp;
    int kd;
    do_reset;
    a_plus           = 32'h0000_0800;
    tau_plus         = 32'h0000_2000;
    dp_weight_change = 32'h0000_1000;
    tc = '0; ap = '0; tp = '0; kd = 0;
    pulse_pre(0, 32'h0001_0000);
    time_now   = 32'h0003_0000;
    post_spike = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      post_spike = 1'b0;
      if (k == 1) begin
        a_plus   = 32'h0000_DEAD;
        tau_plus = 32'h0000_BEEF;
      end
      if (k == 2) begin
        tc = dp_t_change;
        ap = dp_a_plus;
        tp = dp_tau_plus;
      end
      if (done && kd == 0) kd = k;
    end
    checks++; if (tc !== 32'h0002_0000) begin errors++; $display("FAIL single_t_change got %h want 00020000", tc); end
    checks++; if (ap !== 32'h0000_0800) begin errors++; $display("FAIL single_a_plus got %h want 00000800", ap); end
    checks++; if (tp !== 32'h0000_2000) begin errors++; $display("FAIL single_tau_plus got %h want 00002000", tp); end
    checks++; if (kd !== 11) begin errors++; $display("FAIL single_done_cycle got %0d want 11", kd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    rd_idx = 3'd0; #1;
    checks++; if (rd_weight !== 32'h0000_9000) begin errors++; $display("FAIL single_w0 got %h want 00009000", rd_weight); end
    rd_idx = 3'd1; #1;
    checks++; if (rd_weight !== 32'h0000_8000) begin errors++; $display("FAIL single_w1 got %h want 00008000", rd_weight); end
  endtask

  task automatic test_saturation;
    int kd;
    do_reset;
    pulse_pre(1, 32'h0000_1000);
    dp_weight_change = 32'h0000_7000;
    run_sweep(32'h0002_0000, kd);
    rd_idx = 3'd1; #1;
    checks++; if (rd_weight !== 32'h0000_F000) begin errors++; $display("FAIL sat_setup got %h want 0000f000", rd_weight); end
    dp_weight_change = 32'h0000_4000;
    run_sweep(32'h0003_0000, kd);
    rd_idx = 3'd1; #1;
    checks++; if (rd_weight !== 32'h0001_0000) begin errors++; $display("FAIL sat_max got %h want 00010000", rd_weight); end
    checks++; if (kd !== 11) begin errors++; $display("FAIL sat_done_cycle got %0d want 11", kd); end

    do_reset;
    pulse_pre(2, 32'h0005_0000);
    dp_weight_change = 32'hFFFF_0000;
    run_sweep(32'h0001_0000, kd);
    rd_idx = 3'd2; #1;
    checks++; if (rd_weight !== 32'h0000_0000) begin errors++; $display("FAIL sat_min got %h want 00000000", rd_weight); end
    checks++; if (dp_t_change !== 32'hFFFC_0000) begin errors++; $display("FAIL sat_wrap_t got %h want fffc0000", dp_t_change); end
  endtask

  task automatic test_back_to_back;
    logic         d_arr  [0:30];
    logic         b_arr  [0:30];
    logic         pd_arr [0:30];
    logic [N-1:0] tc_arr [0:30];
    int ndone;
    do_reset;
    pulse_pre(3, 32'h0000_1000);
    dp_weight_change = '0;
    ndone      = 0;
    time_now   = 32'h0010_0000;
    post_spike = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      d_arr[k]  = done;
      b_arr[k]  = busy;
      pd_arr[k] = post_dropped;
      tc_arr[k] = dp_t_change;
      if (done) ndone++;
      post_spike = (k == 2) || (k == 3);
      time_now   = (k == 2) ? 32'h0002_0000 : (k == 3) ? 32'h0003_0000 : 32'h0099_0000;
    end
    post_spike = 1'b0;
    checks++; if (tc_arr[5] !== 32'h000F_F000) begin errors++; $display("FAIL b2b_t1 got %h want 000ff000", tc_arr[5]); end
    checks++; if (pd_arr[3] !== 1'b0) begin errors++; $display("FAIL b2b_drop_c3 got %b want 0", pd_arr[3]); end
    checks++; if (pd_arr[4] !== 1'b1) begin errors++; $display("FAIL b2b_drop_c4 got %b want 1", pd_arr[4]); end
    checks++; if (pd_arr[5] !== 1'b0) begin errors++; $display("FAIL b2b_drop_c5 got %b want 0", pd_arr[5]); end
    checks++; if (d_arr[10] !== 1'b0) begin errors++; $display("FAIL b2b_done_c10 got %b want 0", d_arr[10]); end
    checks++; if (d_arr[11] !== 1'b1) begin errors++; $display("FAIL b2b_done_c11 got %b want 1", d_arr[11]); end
    checks++; if (b_arr[12] !== 1'b1 || d_arr[12] !== 1'b0) begin errors++; $display("FAIL b2b_c12 got busy %b done %b want 1 0", b_arr[12], d_arr[12]); end
    checks++; if (tc_arr[16] !== 32'h0002_F000) begin errors++; $display("FAIL b2b_t2 got %h want 0002f000", tc_arr[16]); end
    checks++; if (d_arr[22] !== 1'b1) begin errors++; $display("FAIL b2b_done_c22 got %b want 1", d_arr[22]); end
    checks++; if (b_arr[23] !== 1'b0) begin errors++; $display("FAIL b2b_idle_c23 got %b want 0", b_arr[23]); end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
  endtask

  task automatic test_no_pre;
    int kd;
    do_reset;
    dp_weight_change = 32'h0000_1234;
    run_sweep(32'h0004_0000, kd);
    checks++; if (kd !== 9) begin errors++; $display("FAIL nopre_done_cycle got %0d want 9", kd); end
    for (int i = 0; i < NUM_SYN; i++) begin
      rd_idx = IW'(i);
      #1;
      checks++;
      if (rd_weight !== 32'h0000_8000) begin
        errors++;
        $display("FAIL nopre_w[%0d] got %h want 00008000", i, rd_weight);
      end
    end
  endtask

  task automatic test_reset_mid;
    int ndone, kd;
    do_reset;
    pulse_pre(0, 32'h0000_1000);
    dp_weight_change = 32'h0000_2000;
    time_now   = 32'h0003_0000;
    post_spike = 1'b1;
    tick;
    post_spike = 1'b0;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_wait got %b want 1", busy); end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    rd_idx = 3'd0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    checks++; if (rd_weight !== 32'h0000_8000) begin errors++; $display("FAIL mid_w0 got %h want 00008000", rd_weight); end
    checks++; if (dp_t_change !== 32'h0) begin errors++; $display("FAIL mid_dp_t got %h want 0", dp_t_change); end
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone); end
    run_sweep(32'h0005_0000, kd);
    checks++; if (kd !== 9) begin errors++; $display("FAIL mid_haspre_cleared got %0d want 9", kd); end
  endtask

  task automatic test_same_cycle;
    int kd;
    logic seen;
    do_reset;
    pulse_pre(0, 32'h0001_0000);
    dp_weight_change = '0;
    time_now   = 32'h0005_0000;
    post_spike = 1'b1;
    tick;
    post_spike   = 1'b0;
    pre_spike[0] = 1'b1;
    time_now     = 32'h0004_0000;
    tick;
    pre_spike = '0;
    checks++; if (dp_t_change !== 32'h0004_0000) begin errors++; $display("FAIL same_old_tpre got %h want 00040000", dp_t_change); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL same_done_timeout got %b want 1", seen); end
    tick;
    run_sweep(32'h0006_0000, kd);
    checks++; if (dp_t_change !== 32'h0002_0000) begin errors++; $display("FAIL same_new_tpre got %h want 00020000", dp_t_change); end
    checks++; if (kd !== 11) begin errors++; $display("FAIL same_done_cycle got %0d want 11", kd); end
  endtask

  initial begin
    reset_n          = 1'b0;
    time_now         = '0;
    pre_spike        = '0;
    post_spike       = 1'b0;
    a_plus           = '0;
    tau_plus         = '0;
    dp_weight_change = '0;
    rd_idx           = '0;
    test_reset;
    test_single;
    test_saturation;
    test_back_to_back;
    test_no_pre;
    test_reset_mid;
    test_same_cycle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
